// File: rtl/spy_capture_pkg.sv
// Shared spy-buffer protocol encodings: playback modes and capture FSM states.
package spy_capture_pkg;

    typedef enum logic [1:0] {
        NO_PLAYBACK    = 2'd0,
        PLAYBACK_ONCE  = 2'd1,
        PLAYBACK_LOOP  = 2'd2,
        PLAYBACK_WRITE = 2'd3
    } playback_e;

    typedef enum logic [1:0] {
        CAPTURE      = 2'd0,
        POST_TRIGGER = 2'd1,
        FROZEN       = 2'd2,
        HOLD         = 2'd3
    } cap_state_e;

endpackage

// File: rtl/spy_capture.sv
// Write-side controller for the circular spy memory: records FIFO writes,
// freezes after a programmable post-trigger count, and tracks playback-mode writes.
module spy_capture
    import spy_capture_pkg::*;
#(
    parameter int DATAWIDTH = 64,
    parameter int MEMWIDTH  = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 write_enable,
    input  logic [DATAWIDTH:0]   write_data,
    input  logic                 freeze,
    input  logic [MEMWIDTH-1:0]  freeze_delay,
    input  logic [1:0]           playback,
    input  logic                 playback_ram_write_enable,
    output logic                 spy_write_enable,
    output logic [DATAWIDTH:0]   spy_write_data,
    output logic [MEMWIDTH-1:0]  spy_write_addr,
    output logic                 frozen,
    output logic                 spy_wrapped
);

    localparam logic [MEMWIDTH-1:0] ADDR_MAX = {MEMWIDTH{1'b1}};
    localparam logic [MEMWIDTH-1:0] ONE      = MEMWIDTH'(1);

    cap_state_e            state_q, state_d;
    playback_e             mode;
    logic [MEMWIDTH-1:0]   count_q, count_d;
    logic [MEMWIDTH-1:0]   addr_q, addr_d;
    logic                  wrapped_q, wrapped_d;
    logic                  we_q, we_d;
    logic [DATAWIDTH:0]    data_q, data_d;
    logic                  pb_write_q, pb_write_d;
    logic                  cap_we;
    logic                  pb_entry;
    logic                  pb_step;

    assign mode = playback_e'(playback);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= CAPTURE;
        end else begin
            state_q <= state_d;
        end
    end

    // Any non-idle playback mode pre-empts capture, including a running countdown.
    always_comb begin
        state_d = state_q;
        if (mode != NO_PLAYBACK) begin
            state_d = HOLD;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (freeze) begin
                        state_d = (freeze_delay == '0) ? FROZEN : POST_TRIGGER;
                    end
                end
                POST_TRIGGER: begin
                    if (write_enable && count_q == ONE) begin
                        state_d = FROZEN;
                    end
                end
                FROZEN: begin
                    if (!freeze) begin
                        state_d = CAPTURE;
                    end
                end
                HOLD: begin
                    state_d = freeze ? FROZEN : CAPTURE;
                end
                default: state_d = CAPTURE;
            endcase
        end
    end

    always_comb begin
        cap_we   = write_enable && (mode == NO_PLAYBACK) &&
                   (state_q == CAPTURE || state_q == POST_TRIGGER);
        frozen   = (state_q == FROZEN);
        pb_entry = (mode == PLAYBACK_WRITE) && !pb_write_q;
        pb_step  = (mode == PLAYBACK_WRITE) && pb_write_q && playback_ram_write_enable;
    end

    always_comb begin
        count_d = count_q;
        if (mode != NO_PLAYBACK) begin
            count_d = '0;
        end else if (state_q == CAPTURE && freeze) begin
            count_d = freeze_delay;
        end else if (state_q == POST_TRIGGER && write_enable) begin
            count_d = count_q - ONE;
        end

        // Entering block-write mode restarts the end pointer so the first
        // playback write lands at address 0.
        addr_d    = addr_q;
        wrapped_d = wrapped_q;
        if (pb_entry) begin
            addr_d    = ADDR_MAX;
            wrapped_d = 1'b0;
        end else if (cap_we || pb_step) begin
            addr_d = addr_q + ONE;
            if (addr_d == ADDR_MAX) begin
                wrapped_d = 1'b1;
            end
        end

        pb_write_d = (mode == PLAYBACK_WRITE);
        we_d       = cap_we;
        data_d     = cap_we ? write_data : data_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            addr_q     <= ADDR_MAX;
            wrapped_q  <= 1'b0;
            we_q       <= 1'b0;
            data_q     <= '0;
            pb_write_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            addr_q     <= addr_d;
            wrapped_q  <= wrapped_d;
            we_q       <= we_d;
            data_q     <= data_d;
            pb_write_q <= pb_write_d;
        end
    end

    assign spy_write_enable = we_q;
    assign spy_write_data   = data_q;
    assign spy_write_addr   = addr_q;
    assign spy_wrapped      = wrapped_q;

endmodule
